// File: rtl/bpsk_frame_sync_if.sv
// rtl/bpsk_frame_sync_if.sv - symbol input and byte output bundle for bpsk_frame_sync
interface bpsk_frame_sync_if;
    logic       guess;
    logic       write;
    logic [7:0] data;
    logic       data_valid;
    logic [7:0] length;
    logic       frame_start;
    logic       frame_end;
    logic       inverted;
    logic       error;

    // Demodulator / stimulus side: drives symbols, observes framed bytes
    modport master (
        output guess, write,
        input  data, data_valid, length, frame_start, frame_end, inverted, error
    );

    // Framer side
    modport slave (
        input  guess, write,
        output data, data_valid, length, frame_start, frame_end, inverted, error
    );
endinterface

// File: rtl/bpsk_frame_sync.sv
// rtl/bpsk_frame_sync.sv - BPSK sync-word hunt, length capture and payload byte framing
module bpsk_frame_sync #(
    parameter logic [15:0] SYNC_WORD      = 16'h2DD4,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    bpsk_frame_sync_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_HUNT    = 2'd0;
    localparam logic [1:0] S_LENGTH  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    logic [1:0]    r_state;
    logic [15:0]   r_sr;
    logic [7:0]    r_byte;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_byte_cnt;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_data;
    logic          r_data_valid;
    logic [7:0]    r_length;
    logic          r_frame_start;
    logic          r_frame_end;
    logic          r_inverted;
    logic          r_error;

    logic [15:0]   w_sr_next;
    logic [7:0]    w_byte_next;
    logic [7:0]    w_byte_cnt_next;

    // Post-shift views: sync match and byte completion look at the value including this symbol
    assign w_sr_next       = {r_sr[14:0], bus.guess};
    assign w_byte_next     = {r_byte[6:0], bus.guess ^ r_inverted};
    assign w_byte_cnt_next = r_byte_cnt + 8'd1;

    // Framing state machine; every return to HUNT wipes sr/byte/bit state so stale bits cannot re-match
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_HUNT;
            r_sr          <= '0;
            r_byte        <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_tmo         <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_length      <= '0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_inverted    <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_error       <= 1'b0;
            case (r_state)
                S_HUNT: begin
                    r_tmo <= '0;
                    if (bus.write) begin
                        r_sr <= w_sr_next;
                        if (w_sr_next == SYNC_WORD) begin
                            r_inverted <= 1'b0;
                            r_state    <= S_LENGTH;
                        end else if (w_sr_next == ~SYNC_WORD) begin
                            r_inverted <= 1'b1;
                            r_state    <= S_LENGTH;
                        end
                    end
                end
                S_LENGTH, S_PAYLOAD: begin
                    if (bus.write) begin
                        r_tmo     <= '0;
                        r_byte    <= w_byte_next;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_state == S_LENGTH) begin
                                r_length      <= w_byte_next;
                                r_frame_start <= 1'b1;
                                r_byte_cnt    <= '0;
                                if (w_byte_next == 8'd0) begin
                                    r_frame_end <= 1'b1;
                                    r_state     <= S_HUNT;
                                    r_sr        <= '0;
                                    r_byte      <= '0;
                                end else begin
                                    r_state <= S_PAYLOAD;
                                end
                            end else begin
                                r_data       <= w_byte_next;
                                r_data_valid <= 1'b1;
                                r_byte_cnt   <= w_byte_cnt_next;
                                if (w_byte_cnt_next == r_length) begin
                                    r_frame_end <= 1'b1;
                                    r_state     <= S_HUNT;
                                    r_sr        <= '0;
                                    r_byte      <= '0;
                                end
                            end
                        end
                    end else if (r_tmo == TMO_LIMIT) begin
                        r_error    <= 1'b1;
                        r_state    <= S_HUNT;
                        r_sr       <= '0;
                        r_byte     <= '0;
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_tmo      <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: begin
                    r_state   <= S_HUNT;
                    r_sr      <= '0;
                    r_byte    <= '0;
                    r_bit_cnt <= '0;
                    r_tmo     <= '0;
                end
            endcase
        end
    end

    assign bus.data        = r_data;
    assign bus.data_valid  = r_data_valid;
    assign bus.length      = r_length;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_end   = r_frame_end;
    assign bus.inverted    = r_inverted;
    assign bus.error       = r_error;
endmodule

// File: doc/bpsk_frame_sync.md
# bpsk_frame_sync

Framing stage directly downstream of the BPSK signal demodulator. It consumes the demodulator's per-symbol `guess`/`write` strobe pair and hunts for a 16-bit sync word in either polarity, which resolves the BPSK 180° phase ambiguity. After sync it captures a length byte, then emits the payload as polarity-corrected bytes with start, end and error strobes for the byte-sink logic. A watchdog aborts a frame if the demodulator stops producing confident symbols.

## Interface
Parameters:
- `SYNC_WORD`, 16'h2DD4: sync pattern, MSB first. Must not be all-zeros or all-ones.
- `TIMEOUT_CYCLES`, 256: maximum number of clk cycles allowed between `write` strobes while in a frame.

Ports:
- `clk`  input  1  system clock
- `reset`  input  1  synchronous, active-high; clears all state
- `guess`  input  1  demodulated symbol bit; sampled only when `write`=1
- `write`  input  1  symbol-valid strobe, one cycle per accepted symbol
- `data`  output  8  payload byte, polarity-corrected, MSB received first
- `data_valid`  output  1  one-cycle strobe; `data` is valid
- `length`  output  8  payload length of the current frame; held until the next length capture
- `frame_start`  output  1  one-cycle strobe; `length` has just been captured
- `frame_end`  output  1  one-cycle strobe; the last payload byte has been delivered (or length = 0)
- `inverted`  output  1  1 = sync was matched as ~SYNC_WORD, so payload bits are being inverted
- `error`  output  1  one-cycle strobe; frame aborted by timeout

## Operation
- Reset values: `data`=0, `length`=0, `inverted`=0. All strobes are 0. State = HUNT. Shift registers, bit counter, byte counter and timeout counter are all 0.
- Bits are consumed only on cycles where `write`=1. `guess` is ignored otherwise.
- **HUNT:**
  - 16-bit shift register `sr <= {sr[14:0], guess}` on each write.
  - Match test uses the post-shift value `{sr[14:0], guess}`.
  - == SYNC_WORD: `inverted<=0`, go to LENGTH.
  - == ~SYNC_WORD: `inverted<=1`, go to LENGTH.
  - No partial or error-tolerant matching.
- **LENGTH:**
  - Shift `guess ^ inverted` into an 8-bit byte register and count bits.
  - On the 8th bit: latch `length`, pulse `frame_start`.
  - If length = 0: also pulse `frame_end` and go to HUNT. Otherwise go to PAYLOAD with byte counter = 0.
- **PAYLOAD:**
  - Same byte assembly as LENGTH.
  - On each 8th bit: `data <=` assembled byte, pulse `data_valid`, increment the byte counter.
  - When the byte counter reaches `length`: pulse `frame_end` together with the final `data_valid`, then go to HUNT.
- Sync patterns inside LENGTH/PAYLOAD are ignored; they are treated as data.
- Entering HUNT from any state clears `sr` to 0 and the bit counter to 0, so stale bits cannot re-match.
- **Watchdog:**
  - In LENGTH/PAYLOAD, the counter increments every cycle without `write` and resets to 0 on `write`.
  - When it reaches TIMEOUT_CYCLES: pulse `error`, go to HUNT, and discard the partial byte. No `frame_end` is issued.
  - The counter is held at 0 in HUNT.
  - If `write` and the timeout occur in the same cycle, `write` wins: the bit is consumed and the counter resets.
- `inverted` holds its value until the next sync match or reset.

## Timing
- All outputs are registered.
- `data_valid`/`data`, `frame_start`/`length` and `frame_end` assert exactly one cycle after the clk edge that sampled the completing `write`.
- The state change on a sync match is effective the cycle after the matching `write`. A `write` on that next cycle is the first length bit.
- Back-to-back `write` on consecutive cycles must be supported with no dropped bits.
- A new sync can be matched starting with the first `write` after returning to HUNT. The minimum gap between frames is 16 symbols.
- `error` asserts on the cycle after the counter hits TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES+1 cycles after the last `write`.
- Reset asserted mid-frame: on the next edge all outputs return to reset values, with no `frame_end` or `error` pulse. Reset has priority over every other event.

## Test plan
- Normal frame: bits 0x2DD4, 0x03, 0xA5, 0x0F, 0xC3 with `write` every 4 cycles.
  - Expect `frame_start` with `length`=3.
  - Expect `data_valid` ×3 with 0xA5, 0x0F, 0xC3.
  - Expect `frame_end` coincident with 0xC3, and `inverted`=0.
- Inverted frame: bitwise complement of the same stream, with `write` on every cycle back-to-back.
  - Expect identical bytes and strobes, with `inverted`=1.
- Random prefix and embedded sync:
  - 37 random bits, then the sync word, then length 0x02, then payload 0x2D, 0xD4.
  - Expect one lock and both bytes delivered as data, with no re-sync.
- Zero length: sync, then 0x00.
  - Expect `frame_start` and `frame_end` in the same cycle, no `data_valid`, and a return to HUNT.
- Timeout: sync, length 0x05, 2 payload bytes, then `write` held low.
  - Expect `error` 257 cycles after the last `write`, no `frame_end`, and HUNT.
  - A following valid frame then decodes correctly.
- Reset mid-payload: assert `reset` for 1 cycle after the 4th bit of the first payload byte.
  - Expect all outputs at reset values and no strobes.
  - A subsequent frame decodes correctly.
